piso_uart_ser: RTL and testbench
================================

# piso_uart_ser

Parametrised parallel-in/serial-out byte serialiser between a wide-result producer (e.g. SHA-256 core, 256-bit digest) and the UART transmitter. It captures one DATA_W-bit word through a valid/ready handshake and emits it to the UART TX one character per `tx_dv` pulse. Byte order is selectable, and the word can be sent as raw binary or as uppercase ASCII hex. An optional CR/LF terminator can be appended. It adds a ready/done handshake, UART-idle gating and abort, which the fixed 256-bit serialiser does not have.

## Interface
- `DATA_W`, 256: word width. Must be a multiple of 8 and at least 8; `$error` at elaboration otherwise.
- `MSB_FIRST`, 1: 1 = most-significant byte first; 0 = least-significant byte first.
- `APPEND_CRLF`, 0: 1 = append 0x0D, 0x0A after the payload characters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `word_valid` in 1: producer offers `word_data`.
- `word_data` in DATA_W: word to transmit.
- `hex_mode` in 1: sampled with the word. 1 = ASCII hex (2 chars per byte), 0 = raw binary.
- `word_ready` out 1: block can accept a word.
- `abort` in 1: terminate the current frame.
- `tx_dv` out 1: one-cycle pulse; `tx_byte` is valid.
- `tx_byte` out 8: character to send.
- `tx_done` in 1: UART finished the current character (1-cycle pulse).
- `tx_active` in 1: UART busy.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when the frame has completed.

## Operation
- NBYTES = DATA_W/8.
- NCHARS = NBYTES·(hex ? 2 : 1) + (APPEND_CRLF ? 2 : 0).
- The character counter `char_idx` is $clog2(2·NBYTES+3) bits wide and counts 0..NCHARS−1. It never wraps.
- States: IDLE, LOAD, WAIT_TX.
  - IDLE: `word_ready` = !abort. On `word_valid && word_ready`:
    - latch `word_data` and `hex_mode`;
    - clear `char_idx`;
    - set `busy`;
    - go to LOAD.
  - LOAD: hold while `tx_active` = 1. When `tx_active` = 0:
    - register `tx_byte` = char(`char_idx`) and pulse `tx_dv`;
    - go to WAIT_TX.
  - WAIT_TX: on `tx_done`:
    - if `char_idx` == NCHARS−1: clear `busy`, pulse `done`, go to IDLE;
    - otherwise: increment `char_idx`, go to LOAD.
- `tx_done` is ignored in IDLE and LOAD.
- Byte selection: payload byte k (0-based transmit order) is `word[DATA_W−1−8k -: 8]` when MSB_FIRST = 1, and `word[8k +: 8]` when MSB_FIRST = 0.
- Hex mode:
  - Payload char c encodes byte c/2. The high nibble is sent first (even c).
  - Nibble n maps to 0x30+n for n ≤ 9, and 0x41+(n−10) for n ≥ 10 (uppercase).
- The last two characters are 0x0D then 0x0A when APPEND_CRLF = 1, in both modes.
- Abort in LOAD or WAIT_TX:
  - next state is IDLE, `busy` cleared;
  - no further `tx_dv`, no `done`.
  - A character already handed to the UART completes there.
- Abort in IDLE has no effect other than holding `word_ready` low.
- Abort has priority over `word_valid` and `tx_done` in the same cycle.
- `word_data` and `hex_mode` changes while busy do not affect the frame in progress.

## Timing
- Reset values: `tx_dv` = 0, `tx_byte` = 0x00, `busy` = 0, `done` = 0, state IDLE, `word_ready` = 1 (when `abort` = 0). Internal word register and `char_idx` reset to 0.
- All outputs are registered except `word_ready`, which is decoded from the state and `abort`.
- Handshake accepted at edge k: LOAD from k. With `tx_active` = 0, `tx_dv` is high between edges k+1 and k+2. `busy` is high from k.
- Inter-character: `tx_done` sampled at edge j → LOAD from j → `tx_dv` high between edges j+1 and j+2.
- `tx_done` on the last character sampled at edge j → `done` = 1 and `busy` = 0 between edges j and j+1, with `word_ready` = 1 in the same cycle. A held `word_valid` is accepted at edge j+1, so back-to-back frames leave no idle gap.
- `tx_dv` is never high in two consecutive cycles.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous), and the frame is discarded.

## Structure
- Package `piso_pkg` contains:
  - the `state_t` enum (IDLE, LOAD, WAIT_TX);
  - CR/LF constants;
  - function `hex_ascii(logic [3:0])` returning 8 bits.
- Single module. Character selection is a combinational mux feeding the `tx_byte` register. No sub-module.

## Test plan
- Binary order: DATA_W=32, MSB_FIRST=1, hex=0, word 0xDEADBEEF → `tx_byte` DE, AD, BE, EF. `done` one cycle after the 4th `tx_done`.
- LSB first: MSB_FIRST=0, same word → EF, BE, AD, DE.
- Hex with terminator: hex=1, APPEND_CRLF=1, word 0xDEADBEEF → 44 45 41 44 42 45 45 46 0D 0A, 10 `tx_dv` pulses, one `done`.
- UART gating and spurious done: hold `tx_active` high for 5 cycles after acceptance → first `tx_dv` 1 cycle after `tx_active` falls. A `tx_done` pulse while in LOAD is ignored.
- Abort: DATA_W=256, digest 0x00..1F. Abort in the cycle after the 2nd `tx_done` → exactly 2 `tx_dv` pulses, no `done`, `busy` low next cycle. The next word is accepted normally with first byte 0x00.
- Reset and back-to-back: `rst_n` low mid-frame → outputs at reset values, restart clean. Two words with `word_valid` held → second accepted in the `done` cycle, 8 bytes total, 2 `done` pulses.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out UART byte serialiser.
// Holds the FSM encoding, terminator characters and the nibble-to-ASCII mapping.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      WAIT_TX = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F' ('A' - 10 = 0x37).
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/piso_uart_ser.sv
// Captures one DATA_W-bit word via valid/ready and feeds it to a UART TX one
// character per tx_dv pulse, as raw bytes or uppercase ASCII hex, optional CR/LF.
module piso_uart_ser
   import piso_pkg::*;
#(
   parameter int DATA_W      = 256,
   parameter bit MSB_FIRST   = 1'b1,
   parameter bit APPEND_CRLF = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              word_valid,
   input  logic [DATA_W-1:0] word_data,
   input  logic              hex_mode,
   output logic              word_ready,
   input  logic              abort,
   output logic              tx_dv,
   output logic [7:0]        tx_byte,
   input  logic              tx_done,
   input  logic              tx_active,
   output logic              busy,
   output logic              done
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = $clog2(2 * NBYTES + 3);

   localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NBYTES - 1);
   localparam logic [IDX_W-1:0] BIN_END   = IDX_W'(NBYTES);
   localparam logic [IDX_W-1:0] HEX_END   = IDX_W'(2 * NBYTES);
   localparam logic [IDX_W-1:0] TERM_LEN  = APPEND_CRLF ? IDX_W'(2) : IDX_W'(0);

   generate
      if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
         $error("piso_uart_ser: DATA_W must be a multiple of 8 and at least 8");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                hex_q, hex_d;
   logic [IDX_W-1:0]    char_idx_q, char_idx_d;
   logic [7:0]          tx_byte_q, tx_byte_d;
   logic                tx_dv_q, tx_dv_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [IDX_W-1:0]    pay_end;
   logic [IDX_W-1:0]    last_idx;
   logic [IDX_W-1:0]    byte_k;
   logic [IDX_W-1:0]    byte_pos;
   logic [7:0]          byte_sel;
   logic [3:0]          nib;
   logic [7:0]          char_sel;

   assign word_ready = (state_q == IDLE) && !abort;

   // Character mux: index -> payload byte (or nibble) or terminator.
   always_comb begin
      pay_end  = hex_q ? HEX_END : BIN_END;
      last_idx = pay_end + TERM_LEN - ONE;
      byte_k   = hex_q ? (char_idx_q >> 1) : char_idx_q;
      byte_pos = MSB_FIRST ? (LAST_BYTE - byte_k) : byte_k;

      byte_sel = 8'h00;
      for (int b = 0; b < NBYTES; b++) begin
         if (byte_pos == IDX_W'(b)) begin
            byte_sel = word_q[8*b +: 8];
         end
      end

      nib = char_idx_q[0] ? byte_sel[3:0] : byte_sel[7:4];

      if (APPEND_CRLF && char_idx_q == pay_end) begin
         char_sel = ASCII_CR;
      end else if (APPEND_CRLF && char_idx_q == pay_end + ONE) begin
         char_sel = ASCII_LF;
      end else if (hex_q) begin
         char_sel = hex_ascii(nib);
      end else begin
         char_sel = byte_sel;
      end
   end

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      word_d     = word_q;
      hex_d      = hex_q;
      char_idx_d = char_idx_q;
      tx_byte_d  = tx_byte_q;
      tx_dv_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (word_valid && word_ready) begin
               word_d     = word_data;
               hex_d      = hex_mode;
               char_idx_d = '0;
               busy_d     = 1'b1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (!tx_active) begin
               tx_byte_d = char_sel;
               tx_dv_d   = 1'b1;
               state_d   = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (tx_done) begin
               if (char_idx_q == last_idx) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  char_idx_d = char_idx_q + ONE;
                  state_d    = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_q     <= '0;
         hex_q      <= 1'b0;
         char_idx_q <= '0;
         tx_byte_q  <= 8'h00;
         tx_dv_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         hex_q      <= hex_d;
         char_idx_q <= char_idx_d;
         tx_byte_q  <= tx_byte_d;
         tx_dv_q    <= tx_dv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_dv   = tx_dv_q;
   assign tx_byte = tx_byte_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_piso_uart_ser.sv
// Directed bench for piso_uart_ser: four configurations share control inputs,
// each offered words through its own word_valid; a table drives the plain frames.
module tb_piso_uart_ser;

   logic         clk;
   logic         rst_n;
   logic [3:0]   valid_v;
   logic [31:0]  word_d32;
   logic [255:0] word_d256;
   logic         hex_mode;
   logic         abort;
   logic         tx_done;
   logic         tx_active;

   logic [3:0]   ready_w;
   logic [3:0]   dv_w;
   logic [3:0]   busy_w;
   logic [3:0]   done_w;
   logic [7:0]   byte_w [4];

   int           dv_cnt [4];
   int           done_cnt [4];
   int           total;
   int           bad;
   logic [7:0]   exp_q [$];

   // 0: 32b MSB-first, 1: 32b LSB-first, 2: 32b MSB-first + CRLF, 3: 256b MSB-first
   piso_uart_ser #(.DATA_W(32), .MSB_FIRST(1'b1), .APPEND_CRLF(1'b0)) u_m32 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid_v[0]), .word_data(word_d32),
      .hex_mode(hex_mode), .word_ready(ready_w[0]), .abort(abort), .tx_dv(dv_w[0]),
      .tx_byte(byte_w[0]), .tx_done(tx_done), .tx_active(tx_active),
      .busy(busy_w[0]), .done(done_w[0]));

   piso_uart_ser #(.DATA_W(32), .MSB_FIRST(1'b0), .APPEND_CRLF(1'b0)) u_l32 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid_v[1]), .word_data(word_d32),
      .hex_mode(hex_mode), .word_ready(ready_w[1]), .abort(abort), .tx_dv(dv_w[1]),
      .tx_byte(byte_w[1]), .tx_done(tx_done), .tx_active(tx_active),
      .busy(busy_w[1]), .done(done_w[1]));

   piso_uart_ser #(.DATA_W(32), .MSB_FIRST(1'b1), .APPEND_CRLF(1'b1)) u_h32 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid_v[2]), .word_data(word_d32),
      .hex_mode(hex_mode), .word_ready(ready_w[2]), .abort(abort), .tx_dv(dv_w[2]),
      .tx_byte(byte_w[2]), .tx_done(tx_done), .tx_active(tx_active),
      .busy(busy_w[2]), .done(done_w[2]));

   piso_uart_ser #(.DATA_W(256), .MSB_FIRST(1'b1), .APPEND_CRLF(1'b0)) u_w256 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid_v[3]), .word_data(word_d256),
      .hex_mode(hex_mode), .word_ready(ready_w[3]), .abort(abort), .tx_dv(dv_w[3]),
      .tx_byte(byte_w[3]), .tx_done(tx_done), .tx_active(tx_active),
      .busy(busy_w[3]), .done(done_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (dv_w[i])   dv_cnt[i]   <= dv_cnt[i] + 1;
         if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
      end
   end

   typedef struct {
      int          inst;
      logic        hex;
      logic [31:0] word;
      int          n;
      logic [79:0] exp;   // characters in send order, left-aligned
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Serves every character in exp_q with a 1-cycle UART turnaround; the first
   // tick must show tx_dv (LOAD entered on the preceding edge).
   task automatic serve(input int sel);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         tick();
         check("dv_rise", 64'(dv_w[sel]), 64'd1);
         check("tx_byte", 64'(byte_w[sel]), 64'(exp_q[i]));
         tick();
         check("dv_single", 64'(dv_w[sel]), 64'd0);
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         if (i == n - 1) begin
            check("done_pulse", 64'(done_w[sel]), 64'd1);
            check("busy_end", 64'(busy_w[sel]), 64'd0);
            check("ready_end", 64'(ready_w[sel]), 64'd1);
         end else begin
            check("no_early_done", 64'(done_w[sel]), 64'd0);
         end
      end
   endtask

   task automatic load_32(input logic [31:0] w);
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(w[31-8*k -: 8]);
   endtask

   initial begin
      int          d0;
      int          n0;
      int          gated_dv;
      logic [79:0] e;
      logic [31:0] w;

      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      valid_v   = 4'h0;
      word_d32  = 32'h0;
      word_d256 = '0;
      hex_mode  = 1'b0;
      abort     = 1'b0;
      tx_done   = 1'b0;
      tx_active = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dv_cnt[i]   = 0;
         done_cnt[i] = 0;
      end

      vecs[0] = '{0, 1'b0, 32'hDEADBEEF, 4,  80'hDEADBEEF000000000000};
      vecs[1] = '{1, 1'b0, 32'hDEADBEEF, 4,  80'hEFBEADDE000000000000};
      vecs[2] = '{2, 1'b1, 32'hDEADBEEF, 10, 80'h44454144424545460D0A};
      vecs[3] = '{0, 1'b1, 32'h0123ABCF, 8,  80'h30313233414243460000};
      vecs[4] = '{2, 1'b0, 32'h00FF7F80, 6,  80'h00FF7F800D0A00000000};
      vecs[5] = '{1, 1'b1, 32'h12345678, 8,  80'h37383536333431320000};

      // Reset values
      tick();
      tick();
      check("rst_dv", 64'(dv_w), 64'h0);
      check("rst_busy", 64'(busy_w), 64'h0);
      check("rst_done", 64'(done_w), 64'h0);
      check("rst_ready", 64'(ready_w), 64'hF);
      for (int i = 0; i < 4; i++) check("rst_byte", 64'(byte_w[i]), 64'h0);
      rst_n = 1'b1;
      tick();

      // Table-driven plain frames
      for (int j = 0; j < 6; j++) begin
         d0 = dv_cnt[vecs[j].inst];
         n0 = done_cnt[vecs[j].inst];
         hex_mode = vecs[j].hex;
         word_d32 = vecs[j].word;
         valid_v[vecs[j].inst] = 1'b1;
         tick();
         valid_v = 4'h0;
         hex_mode = ~vecs[j].hex;
         word_d32 = 32'h55AA55AA;
         check("accept_busy", 64'(busy_w[vecs[j].inst]), 64'd1);
         check("accept_ready", 64'(ready_w[vecs[j].inst]), 64'd0);
         check("accept_dv", 64'(dv_w[vecs[j].inst]), 64'd0);
         e = vecs[j].exp;
         exp_q.delete();
         for (int i = 0; i < vecs[j].n; i++) exp_q.push_back(e[79-8*i -: 8]);
         serve(vecs[j].inst);
         tick();
         check("done_once", 64'(done_w[vecs[j].inst]), 64'd0);
         check("dv_count", 64'(dv_cnt[vecs[j].inst] - d0), 64'(vecs[j].n));
         check("done_count", 64'(done_cnt[vecs[j].inst] - n0), 64'd1);
      end

      // UART-idle gating with a spurious tx_done while in LOAD
      hex_mode  = 1'b0;
      word_d32  = 32'hDEADBEEF;
      tx_active = 1'b1;
      valid_v[0] = 1'b1;
      tick();
      valid_v = 4'h0;
      gated_dv = 0;
      for (int i = 0; i < 5; i++) begin
         tx_done = (i == 1);
         tick();
         if (dv_w[0]) gated_dv++;
      end
      tx_done   = 1'b0;
      tx_active = 1'b0;
      check("gated_dv", 64'(gated_dv), 64'd0);
      load_32(32'hDEADBEEF);
      serve(0);
      tick();

      // Abort after the second tx_done on the 256-bit instance
      for (int k = 0; k < 32; k++) word_d256[255-8*k -: 8] = 8'(k);
      d0 = dv_cnt[3];
      n0 = done_cnt[3];
      valid_v[3] = 1'b1;
      tick();
      valid_v = 4'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("abort_pre_byte", 64'(byte_w[3]), 64'(i));
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
      abort = 1'b1;
      valid_v[3] = 1'b1;
      tick();
      check("abort_dv", 64'(dv_w[3]), 64'd0);
      check("abort_busy", 64'(busy_w[3]), 64'd0);
      check("abort_ready", 64'(ready_w[3]), 64'd0);
      tick();
      check("abort_over_valid", 64'(busy_w[3]), 64'd0);
      valid_v = 4'h0;
      abort = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("abort_dv_count", 64'(dv_cnt[3] - d0), 64'd2);
      check("abort_no_done", 64'(done_cnt[3] - n0), 64'd0);
      valid_v[3] = 1'b1;
      tick();
      valid_v = 4'h0;
      check("post_abort_busy", 64'(busy_w[3]), 64'd1);
      exp_q.delete();
      for (int k = 0; k < 32; k++) exp_q.push_back(8'(k));
      serve(3);
      tick();

      // Asynchronous reset mid-frame, then a clean restart
      word_d32 = 32'hDEADBEEF;
      valid_v[0] = 1'b1;
      tick();
      valid_v = 4'h0;
      tick();
      check("mid_dv", 64'(dv_w[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_dv", 64'(dv_w[0]), 64'd0);
      check("arst_byte", 64'(byte_w[0]), 64'h0);
      check("arst_busy", 64'(busy_w[0]), 64'd0);
      check("arst_ready", 64'(ready_w[0]), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      valid_v[0] = 1'b1;
      tick();
      valid_v = 4'h0;
      load_32(32'hDEADBEEF);
      serve(0);
      tick();

      // Back-to-back frames with word_valid held
      d0 = dv_cnt[0];
      n0 = done_cnt[0];
      word_d32 = 32'hDEADBEEF;
      valid_v[0] = 1'b1;
      tick();
      word_d32 = 32'h01234567;
      load_32(32'hDEADBEEF);
      serve(0);
      tick();
      check("b2b_accept", 64'(busy_w[0]), 64'd1);
      check("b2b_done_low", 64'(done_w[0]), 64'd0);
      valid_v = 4'h0;
      w = 32'h01234567;
      load_32(w);
      serve(0);
      tick();
      check("b2b_dv_count", 64'(dv_cnt[0] - d0), 64'd8);
      check("b2b_done_count", 64'(done_cnt[0] - n0), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
